// File: rtl/mips_noc_iface.sv
// -----------------------------------------------------------------------------
// mips_noc_iface
//
// Network interface between a MIPS pipeline node and its local NoC router
// port. Outgoing words are framed as {dest, src, data} flits and buffered in a
// first-word-fall-through TX FIFO. Incoming flits addressed to this node are
// buffered as {src, data} in a first-word-fall-through RX FIFO. Flits
// addressed to any other node are accepted and discarded.
//
// Optional feature macro: NOC_IFACE_STATS_EN
//   defined   : saturating 16-bit tx/rx/drop statistics counters are built
//   undefined : no counter registers; the statistics outputs read 16'h0000
//
// Parameters
//   DATA_W  payload width
//   ADDR_W  node address width
//   DEPTH   entries per FIFO (power of two, >= 2)
//   NODE_ID this node's address
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   proc_valid/dest/data/ready    processor -> TX FIFO push handshake
//   proc_rx_valid/data/src/ready  RX FIFO head -> processor pop handshake
//   net_tx_valid/flit/ready       TX FIFO head -> router
//   net_rx_valid/flit/ready       router -> RX FIFO (filtered by dest)
//   tx_count/rx_count/drop_count  statistics (see macro above)
// -----------------------------------------------------------------------------
module mips_noc_iface #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 2,
   parameter int DEPTH   = 4,
   parameter int NODE_ID = 0,
   localparam int FLIT_W = 2 * ADDR_W + DATA_W
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              proc_valid,
   input  logic [ADDR_W-1:0] proc_dest,
   input  logic [DATA_W-1:0] proc_data,
   output logic              proc_ready,

   output logic              proc_rx_valid,
   output logic [DATA_W-1:0] proc_rx_data,
   output logic [ADDR_W-1:0] proc_rx_src,
   input  logic              proc_rx_ready,

   output logic              net_tx_valid,
   output logic [FLIT_W-1:0] net_tx_flit,
   input  logic              net_tx_ready,

   input  logic              net_rx_valid,
   input  logic [FLIT_W-1:0] net_rx_flit,
   output logic              net_rx_ready,

   output logic [15:0]       tx_count,
   output logic [15:0]       rx_count,
   output logic [15:0]       drop_count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int RXE_W  = ADDR_W + DATA_W;   // stored RX entry: {src, data}

   localparam logic [ADDR_W-1:0] MY_ID   = NODE_ID[ADDR_W-1:0];
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   // ---------------------------------------------------------------- TX FIFO
   logic [FLIT_W-1:0] tx_mem [DEPTH];
   logic [PTR_W-1:0]  tx_wr_ptr, tx_rd_ptr;
   logic [CNT_W-1:0]  tx_cnt;
   logic              tx_push, tx_pop;

   // Handshakes come from the registered count only, so no combinational
   // path runs from any valid input to any ready output.
   assign proc_ready   = (tx_cnt != CNT_MAX);
   assign net_tx_valid = (tx_cnt != '0);
   assign net_tx_flit  = tx_mem[tx_rd_ptr];

   assign tx_push = proc_valid && proc_ready;
   assign tx_pop  = net_tx_valid && net_tx_ready;

   // NOTE: sequential state uses non-blocking (<=) assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_cnt    <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
            2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   // NOTE: FIFO storage is deliberately left out of reset; an entry is only
   // ever read after it has been written, and skipping the reset keeps the
   // array mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= {proc_dest, MY_ID, proc_data};
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [RXE_W-1:0]  rx_mem [DEPTH];
   logic [PTR_W-1:0]  rx_wr_ptr, rx_rd_ptr;
   logic [CNT_W-1:0]  rx_cnt;
   logic              rx_accept, rx_store, rx_pop;
   logic [ADDR_W-1:0] rx_dest;
   logic [RXE_W-1:0]  rx_head;

   assign net_rx_ready  = (rx_cnt != CNT_MAX);
   assign proc_rx_valid = (rx_cnt != '0);
   assign rx_head       = rx_mem[rx_rd_ptr];
   assign proc_rx_src   = rx_head[RXE_W-1 -: ADDR_W];
   assign proc_rx_data  = rx_head[DATA_W-1:0];

   assign rx_dest   = net_rx_flit[FLIT_W-1 -: ADDR_W];
   assign rx_accept = net_rx_valid && net_rx_ready;
   // A flit for another node is still accepted (it leaves the router port)
   // but never written into the FIFO.
   assign rx_store  = rx_accept && (rx_dest == MY_ID);
   assign rx_pop    = proc_rx_valid && proc_rx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_cnt    <= '0;
      end else begin
         if (rx_store) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         if (rx_pop)   rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
         case ({rx_store, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
            2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rx_store) rx_mem[rx_wr_ptr] <= net_rx_flit[RXE_W-1:0];
   end

   // ------------------------------------------------------------- statistics
`ifdef NOC_IFACE_STATS_EN
   logic [15:0] tx_cnt_q, rx_cnt_q, drop_cnt_q;
   logic        rx_drop;

   assign rx_drop = rx_accept && (rx_dest != MY_ID);

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (tx_pop   && (tx_cnt_q   != 16'hFFFF)) tx_cnt_q   <= tx_cnt_q   + 16'd1;
         if (rx_store && (rx_cnt_q   != 16'hFFFF)) rx_cnt_q   <= rx_cnt_q   + 16'd1;
         if (rx_drop  && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign tx_count   = tx_cnt_q;
   assign rx_count   = rx_cnt_q;
   assign drop_count = drop_cnt_q;
`else
   assign tx_count   = 16'h0000;
   assign rx_count   = 16'h0000;
   assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mips_noc_iface.sv
// -----------------------------------------------------------------------------
// tb_mips_noc_iface
//
// Directed, self-checking bench for mips_noc_iface with NODE_ID = 1.
// Expected TX flits and RX entries are pushed to scoreboard queues when the
// stimulus is driven and popped when the DUT presents them. Statistics
// expectations follow NOC_IFACE_STATS_EN (zero when the macro is undefined).
// -----------------------------------------------------------------------------
module tb_mips_noc_iface;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 2;
   localparam int DEPTH   = 4;
   localparam int NODE_ID = 1;
   localparam int FLIT_W  = 2 * ADDR_W + DATA_W;
   localparam int RXE_W   = ADDR_W + DATA_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              proc_valid;
   logic [ADDR_W-1:0] proc_dest;
   logic [DATA_W-1:0] proc_data;
   logic              proc_ready;
   logic              proc_rx_valid;
   logic [DATA_W-1:0] proc_rx_data;
   logic [ADDR_W-1:0] proc_rx_src;
   logic              proc_rx_ready;
   logic              net_tx_valid;
   logic [FLIT_W-1:0] net_tx_flit;
   logic              net_tx_ready;
   logic              net_rx_valid;
   logic [FLIT_W-1:0] net_rx_flit;
   logic              net_rx_ready;
   logic [15:0]       tx_count, rx_count, drop_count;

   mips_noc_iface #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NODE_ID(NODE_ID)
   ) dut (
      .clk(clk), .rst(rst),
      .proc_valid(proc_valid), .proc_dest(proc_dest), .proc_data(proc_data),
      .proc_ready(proc_ready),
      .proc_rx_valid(proc_rx_valid), .proc_rx_data(proc_rx_data),
      .proc_rx_src(proc_rx_src), .proc_rx_ready(proc_rx_ready),
      .net_tx_valid(net_tx_valid), .net_tx_flit(net_tx_flit),
      .net_tx_ready(net_tx_ready),
      .net_rx_valid(net_rx_valid), .net_rx_flit(net_rx_flit),
      .net_rx_ready(net_rx_ready),
      .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [FLIT_W-1:0] tx_q[$];   // expected flits at net_tx_flit, in order
   logic [RXE_W-1:0]  rx_q[$];   // expected {src, data} at the RX head
   int exp_tx = 0, exp_rx = 0, exp_drop = 0;

   function automatic logic [15:0] stat(input int n);
`ifdef NOC_IFACE_STATS_EN
      return 16'(n);
`else
      return 16'(0 * n);
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; outputs are sampled / inputs changed 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_stats(input string tag);
      check({tag, " tx_count"},   64'(tx_count),   64'(stat(exp_tx)));
      check({tag, " rx_count"},   64'(rx_count),   64'(stat(exp_rx)));
      check({tag, " drop_count"}, 64'(drop_count), 64'(stat(exp_drop)));
   endtask

   // Compare the TX head against the scoreboard, then pop it this edge.
   task automatic tx_pop_check(input string tag);
      logic [FLIT_W-1:0] e;
      e = tx_q.pop_front();
      check({tag, " tx valid"}, 64'(net_tx_valid), 64'(1));
      check({tag, " tx flit"},  64'(net_tx_flit),  64'(e));
      net_tx_ready = 1'b1;
      step();
      exp_tx++;
   endtask

   task automatic rx_head_check(input string tag);
      logic [RXE_W-1:0] e;
      e = rx_q.pop_front();
      check({tag, " rx valid"}, 64'(proc_rx_valid), 64'(1));
      check({tag, " rx src"},   64'(proc_rx_src),   64'(e[RXE_W-1 -: ADDR_W]));
      check({tag, " rx data"},  64'(proc_rx_data),  64'(e[DATA_W-1:0]));
   endtask

   function automatic logic [FLIT_W-1:0] mk_flit(input logic [ADDR_W-1:0] d,
                                                input logic [ADDR_W-1:0] s,
                                                input logic [DATA_W-1:0] w);
      return {d, s, w};
   endfunction

   initial begin
      logic [FLIT_W-1:0] f;
      logic [1:0] me;
      me = 2'(NODE_ID);

      rst = 1'b1; proc_valid = 1'b0; proc_dest = '0; proc_data = '0;
      proc_rx_ready = 1'b0; net_tx_ready = 1'b0; net_rx_valid = 1'b0; net_rx_flit = '0;
      step(); step();
      rst = 1'b0;
      step();

      // ---- reset state
      check("rst proc_ready",    64'(proc_ready),    64'(1));
      check("rst net_rx_ready",  64'(net_rx_ready),  64'(1));
      check("rst proc_rx_valid", 64'(proc_rx_valid), 64'(0));
      check("rst net_tx_valid",  64'(net_tx_valid),  64'(0));
      check_stats("rst");

      // ---- single TX word, held by router backpressure
      proc_valid = 1'b1; proc_dest = 2'd2; proc_data = 32'hDEADBEEF;
      tx_q.push_back(mk_flit(2'd2, me, 32'hDEADBEEF));
      step();
      proc_valid = 1'b0;
      check("tx1 valid", 64'(net_tx_valid), 64'(1));
      check("tx1 flit",  64'(net_tx_flit),  64'(tx_q[0]));
      step(); step();
      check("tx1 hold valid", 64'(net_tx_valid), 64'(1));
      check("tx1 hold flit",  64'(net_tx_flit),  64'(tx_q[0]));
      tx_pop_check("tx1 pop");
      net_tx_ready = 1'b0;
      check("tx1 empty", 64'(net_tx_valid), 64'(0));

      // ---- fill TX, try a push while full, then drain back-to-back
      for (int i = 1; i <= DEPTH; i++) begin
         proc_valid = 1'b1; proc_dest = 2'(i); proc_data = 32'hA000_0000 + 32'(i);
         tx_q.push_back(mk_flit(2'(i), me, 32'hA000_0000 + 32'(i)));
         step();
      end
      check("txfull proc_ready", 64'(proc_ready), 64'(0));
      proc_data = 32'hBAD0_0005;          // refused: FIFO full
      step();
      proc_valid = 1'b0;
      check("txfull still full", 64'(proc_ready), 64'(0));
      for (int i = 0; i < DEPTH; i++) tx_pop_check("txdrain");
      net_tx_ready = 1'b0;
      check("txdrain empty",      64'(net_tx_valid), 64'(0));
      check("txdrain proc_ready", 64'(proc_ready),   64'(1));
      check_stats("txdrain");

      // ---- simultaneous TX push and pop on a non-empty FIFO
      proc_valid = 1'b1; proc_dest = 2'd3; proc_data = 32'h1111_0001;
      tx_q.push_back(mk_flit(2'd3, me, 32'h1111_0001));
      step();
      proc_data = 32'h1111_0002;
      tx_q.push_back(mk_flit(2'd3, me, 32'h1111_0002));
      tx_pop_check("txboth");
      proc_valid = 1'b0;
      tx_pop_check("txboth tail");
      net_tx_ready = 1'b0;
      check("txboth empty", 64'(net_tx_valid), 64'(0));

      // ---- RX for this node, then a flit for another node (dropped)
      net_rx_valid = 1'b1; net_rx_flit = mk_flit(me, 2'd3, 32'h12345678);
      rx_q.push_back({2'd3, 32'h12345678});
      exp_rx++;
      step();
      net_rx_valid = 1'b0;
      rx_head_check("rx1");
      proc_rx_ready = 1'b1;
      step();
      proc_rx_ready = 1'b0;
      check("rx1 empty", 64'(proc_rx_valid), 64'(0));

      net_rx_valid = 1'b1; net_rx_flit = mk_flit(2'd0, 2'd2, 32'hCAFEF00D);
      check("drop rx_ready", 64'(net_rx_ready), 64'(1));
      exp_drop++;
      step();
      net_rx_valid = 1'b0;
      check("drop not stored", 64'(proc_rx_valid), 64'(0));
      check("drop rx_ready after", 64'(net_rx_ready), 64'(1));
      check_stats("drop");

      // ---- RX full: push+pop same cycle -> only pop; next cycle both
      for (int i = 0; i < DEPTH; i++) begin
         net_rx_valid = 1'b1; net_rx_flit = mk_flit(me, 2'(i), 32'h5000_0000 + 32'(i));
         rx_q.push_back({2'(i), 32'h5000_0000 + 32'(i)});
         exp_rx++;
         step();
      end
      check("rxfull ready", 64'(net_rx_ready), 64'(0));
      f = mk_flit(me, 2'd2, 32'h7777_7777);
      net_rx_flit = f; proc_rx_ready = 1'b1;
      rx_head_check("rxfull pop");
      step();                               // only the pop (count 3)
      check("rxfull after ready", 64'(net_rx_ready), 64'(1));
      rx_head_check("rxboth pop");
      rx_q.push_back(f[RXE_W-1:0]);
      exp_rx++;
      step();                               // push and pop (count stays 3)
      net_rx_valid = 1'b0; proc_rx_ready = 1'b0;
      check("rxboth ready", 64'(net_rx_ready), 64'(1));
      for (int i = 0; i < 3; i++) begin
         rx_head_check("rxdrain");
         proc_rx_ready = 1'b1;
         step();
         proc_rx_ready = 1'b0;
      end
      check("rxdrain empty", 64'(proc_rx_valid), 64'(0));
      check_stats("rxdrain");

      // ---- reset mid-operation with 3 TX entries and a push in the reset cycle
      for (int i = 0; i < 3; i++) begin
         proc_valid = 1'b1; proc_dest = 2'd0; proc_data = 32'hEEEE_0000 + 32'(i);
         step();
      end
      rst = 1'b1; proc_data = 32'hEEEE_00FF;
      step();
      rst = 1'b0; proc_valid = 1'b0;
      tx_q.delete();
      exp_tx = 0; exp_rx = 0; exp_drop = 0;
      check("mrst tx_valid",   64'(net_tx_valid), 64'(0));
      check("mrst proc_ready", 64'(proc_ready),   64'(1));
      check_stats("mrst");
      proc_valid = 1'b1; proc_dest = 2'd2; proc_data = 32'h0BAD_CAFE;
      tx_q.push_back(mk_flit(2'd2, me, 32'h0BAD_CAFE));
      step();
      proc_valid = 1'b0;
      tx_pop_check("mrst alone");
      net_tx_ready = 1'b0;
      check("mrst alone empty", 64'(net_tx_valid), 64'(0));
      check_stats("mrst end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard bound in case the clock or stimulus is ever broken.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
